perceptron_sequencer: RTL and testbench



---
 rtl/perceptron_sequencer.sv | 109 ++++++++++
 tb/tb_perceptron_sequencer.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/perceptron_sequencer.sv
// Single-neuron perceptron sequencer: accumulates N_INPUTS Q2.14 x*w beats onto a bias,
// hands the Q34.14 sum to an external activation unit and returns its registered result.
module perceptron_sequencer #(
  parameter int N_INPUTS = 4,
  parameter int CNT_W    = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] bias,
  output logic        busy,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_x,
  input  logic [15:0] in_w,
  output logic [47:0] act_x,
  input  logic [15:0] act_y,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_y
);

  typedef enum logic [2:0] {
    IDLE,
    ACCUM,
    ACT,
    CAPTURE,
    OUTPUT
  } state_t;

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(N_INPUTS - 1);

  state_t             state, state_nx;
  logic [47:0]        acc;
  logic [CNT_W-1:0]   cnt;
  logic               beat;
  logic               last_beat;
  logic signed [15:0] x_s;
  logic signed [15:0] w_s;
  logic signed [31:0] prod;
  logic [47:0]        prod_q14;

  assign x_s  = in_x;
  assign w_s  = in_w;
  assign prod = x_s * w_s;
  // Q4.28 -> Q.14 by arithmetic shift (floor), then sign-extend into the accumulator width
  assign prod_q14 = {{30{prod[31]}}, prod[31:14]};

  assign beat      = (state == ACCUM) && in_valid;
  assign last_beat = beat && (cnt == LAST_BEAT);
  assign act_x     = acc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = ACCUM;
      ACCUM:   if (last_beat) state_nx = ACT;
      ACT:     state_nx = CAPTURE;
      CAPTURE: state_nx = OUTPUT;
      OUTPUT:  if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy      = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      IDLE:    busy = 1'b0;
      ACCUM:   begin busy = 1'b1; in_ready = 1'b1; end
      ACT:     busy = 1'b1;
      CAPTURE: busy = 1'b1;
      OUTPUT:  begin busy = 1'b1; out_valid = 1'b1; end
      default: busy = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      cnt <= '0;
    end else if ((state == IDLE) && start) begin
      acc <= {{32{bias[15]}}, bias};
      cnt <= '0;
    end else if (beat) begin
      acc <= acc + prod_q14;
      cnt <= cnt + CNT_W'(1);
    end
  end

  // act_y is valid during CAPTURE since the activation unit registers act_x once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_y <= '0;
    end else if (state == CAPTURE) begin
      out_y <= act_y;
    end
  end

endmodule

// File: tb/tb_perceptron_sequencer.sv
// Scoreboard bench for perceptron_sequencer with a registered clamp-style activation model.
module tb_perceptron_sequencer;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] bias;
  logic        busy;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_x;
  logic [15:0] in_w;
  logic [47:0] act_x;
  logic [15:0] act_y;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_y;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [47:0] acc;
    logic [15:0] y;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  perceptron_sequencer #(.N_INPUTS(N), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .bias(bias), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_w(in_w),
    .act_x(act_x), .act_y(act_y), .out_valid(out_valid),
    .out_ready(out_ready), .out_y(out_y)
  );

  // Activation unit: clamp to +/-1.0, one register stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) act_y <= '0;
    else if ($signed(act_x) > 48'sd16384) act_y <= 16'h4000;
    else if ($signed(act_x) < -48'sd16384) act_y <= 16'hC000;
    else act_y <= act_x[15:0];
  end

  task automatic check(input string name, input logic [47:0] got, input logic [47:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_output: got out_y=%h expected no output", out_y);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("mon_out_y", {32'h0, out_y}, {32'h0, e.y});
        check("mon_act_x", act_x, e.acc);
      end
    end
  end

  task automatic run_eval(input logic [15:0] b, input logic [15:0] x, input logic [15:0] w,
                          input logic [7:0] pat, input int plen, input int hold,
                          input bit start_in_out, input logic [47:0] eacc,
                          input logic [15:0] ey, input string tag);
    int e;
    sb.push_back(exp_t'{eacc, ey});
    start = 1'b1;
    bias  = b;
    @(posedge clk); #1;
    start = 1'b0;
    e = 0;
    check({tag, "_busy_start"}, {47'h0, busy}, 48'h1);
    for (int i = 0; i < plen; i++) begin
      in_valid = pat[i];
      in_x = x;
      in_w = w;
      @(posedge clk); #1;
      e++;
    end
    in_valid = 1'b1;  // extra beats offered after the last one must be ignored
    for (int k = 0; k < 30 && !out_valid; k++) begin
      @(posedge clk); #1;
      e++;
    end
    in_valid = 1'b0;
    if (!out_valid) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: got out_valid=0 expected 1 within 30 cycles", tag);
    end else begin
      check({tag, "_latency"}, 48'(e), 48'(plen + 2));
    end
    out_ready = 1'b0;
    start = start_in_out;
    for (int h = 0; h < hold; h++) begin
      check({tag, "_hold_out_y"}, {32'h0, out_y}, {32'h0, ey});
      check({tag, "_hold_valid"}, {47'h0, out_valid}, 48'h1);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    start = 1'b0;
    check({tag, "_busy_after_hs"}, {47'h0, busy}, 48'h0);
    check({tag, "_out_y_retained"}, {32'h0, out_y}, {32'h0, ey});
    @(posedge clk); #1;
    check({tag, "_idle_stays"}, {47'h0, busy}, 48'h0);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    bias = '0;
    in_valid = 1'b0;
    in_x = '0;
    in_w = '0;
    out_ready = 1'b0;
    #12;
    check("rst_busy", {47'h0, busy}, 48'h0);
    check("rst_in_ready", {47'h0, in_ready}, 48'h0);
    check("rst_out_valid", {47'h0, out_valid}, 48'h0);
    check("rst_out_y", {32'h0, out_y}, 48'h0);
    check("rst_act_x", act_x, 48'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    run_eval(16'h0000, 16'h4000, 16'h2000, 8'h0F, 4, 1, 1'b0, 48'h0000_0000_8000, 16'h4000, "pos_sat");
    run_eval(16'h0000, 16'h4000, 16'h1000, 8'h0F, 4, 1, 1'b0, 48'h0000_0000_4000, 16'h4000, "exact_one");
    run_eval(16'h0800, 16'h4000, 16'hF000, 8'h0F, 4, 1, 1'b0, 48'hFFFF_FFFF_C800, 16'hC800, "neg_bias");
    run_eval(16'h0000, 16'h4000, 16'hF000, 8'h0F, 4, 1, 1'b0, 48'hFFFF_FFFF_C000, 16'hC000, "neg_one");
    run_eval(16'h0000, 16'h4000, 16'hE000, 8'h0F, 4, 1, 1'b0, 48'hFFFF_FFFF_8000, 16'hC000, "neg_sat");
    run_eval(16'h0000, 16'h0001, 16'hFFFF, 8'h0F, 4, 1, 1'b0, 48'hFFFF_FFFF_FFFC, 16'hFFFC, "floor");
    run_eval(16'h0000, 16'h4000, 16'h2000, 8'h59, 7, 5, 1'b0, 48'h0000_0000_8000, 16'h4000, "stall");

    start = 1'b1;
    bias = 16'h1234;
    @(posedge clk); #1;
    start = 1'b0;
    in_valid = 1'b1;
    in_x = 16'h4000;
    in_w = 16'h2000;
    @(posedge clk); #1;
    @(posedge clk); #1;
    #2 rst = 1'b1;
    #1;
    check("midrst_busy", {47'h0, busy}, 48'h0);
    check("midrst_in_ready", {47'h0, in_ready}, 48'h0);
    check("midrst_out_valid", {47'h0, out_valid}, 48'h0);
    check("midrst_out_y", {32'h0, out_y}, 48'h0);
    check("midrst_act_x", act_x, 48'h0);
    in_valid = 1'b0;
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_idle", {47'h0, busy}, 48'h0);

    run_eval(16'h0000, 16'h4000, 16'h1000, 8'h0F, 4, 2, 1'b1, 48'h0000_0000_4000, 16'h4000, "start_in_output");

    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
